vehicle_sensor_conditioner: RTL and testbench

//  Upstream stage of the traffic light controller: turns the raw side-street loop-detector

---
 rtl/vehicle_sensor_conditioner_pkg.sv | 27 ++
 rtl/vehicle_sensor_conditioner_if.sv | 29 ++
 rtl/vehicle_sensor_conditioner_sync_debounce.sv | 61 ++++++
 rtl/vehicle_sensor_conditioner.sv | 97 +++++++++
 tb/tb_vehicle_sensor_conditioner.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vehicle_sensor_conditioner_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vehicle_sensor_conditioner_pkg                                       |
// | Shared lamp encoding and request-FSM state type for the side-street  |
// | vehicle sensor conditioner.                                          |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package vehicle_sensor_conditioner_pkg;

  // Lamp encoding shared with the traffic light controller; 2'b11 is unused
  // and is treated as not-green everywhere.
  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SERVING = 2'd2
  } sensor_state_t;

  function automatic logic is_green(input logic [1:0] light);
    return light == GREEN;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vehicle_sensor_conditioner_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vehicle_sensor_conditioner_if                                        |
// | Loop-detector input, side-street lamp input and the conditioned      |
// | request/status outputs, bundled for the conditioner.                 |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
interface vehicle_sensor_conditioner_if #(
  parameter int CNT_W = 8
);
  logic             loop_raw;
  logic [1:0]       side_light;
  logic             sensor;
  logic             fault;
  logic [CNT_W-1:0] vehicle_count;

  // Environment side: drives the detector and lamp, observes the request.
  modport master (
    output loop_raw, side_light,
    input  sensor, fault, vehicle_count
  );

  // Conditioner side.
  modport slave (
    input  loop_raw, side_light,
    output sensor, fault, vehicle_count
  );
endinterface
`default_nettype wire

// File: rtl/vehicle_sensor_conditioner_sync_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_debounce                                                        |
// | Two-flop synchroniser followed by a stability-count debouncer.       |
// | Produces the debounced level and a one-cycle rising-edge pulse.      |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module sync_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic d_async,
  output logic      level,
  output logic      rise
);

  localparam int CW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE);

  logic          meta;
  logic          synced;
  logic          level_q;
  logic [CW-1:0] cnt;

  // Two-stage synchroniser for the asynchronous detector contact.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta   <= 1'b0;
      synced <= 1'b0;
    end else begin
      meta   <= d_async;
      synced <= meta;
    end
  end

  // The level only follows the synced input after DEBOUNCE consecutive
  // disagreeing samples; any agreeing sample restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (synced == level) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE - 1)) begin
      level <= synced;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Delayed copy of the level for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) level_q <= 1'b0;
    else       level_q <= level;
  end

  assign rise = level & ~level_q;

endmodule
`default_nettype wire

// File: rtl/vehicle_sensor_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vehicle_sensor_conditioner                                           |
// | Turns the raw side-street loop contact into a latched request held   |
// | until the side street is served; counts arrivals and forces a        |
// | fail-safe recall when the detector appears stuck on.                 |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module vehicle_sensor_conditioner
  import vehicle_sensor_conditioner_pkg::*;
#(
  parameter int DEBOUNCE     = 4,
  parameter int STUCK_CYCLES = 1024,
  parameter int CNT_W        = 8
) (
  input wire logic                   clk,
  input wire logic                   reset,
  vehicle_sensor_conditioner_if.slave bus
);

  localparam int SCNT_W = $clog2(STUCK_CYCLES + 1);

  logic             det;
  logic             det_rise;
  logic             green;
  sensor_state_t    state;
  sensor_state_t    state_next;
  logic [SCNT_W-1:0] scnt;
  logic             fault_q;
  logic             fault_set;
  logic             sensor_q;
  logic [CNT_W-1:0] count_q;

  sync_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_sync_debounce (
    .clk     (clk),
    .reset   (reset),
    .d_async (bus.loop_raw),
    .level   (det),
    .rise    (det_rise)
  );

  assign green = is_green(bus.side_light);

  // Request FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Request FSM transitions: a request is held until green, and re-raised
  // after green if the vehicle is still on the loop.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (det_rise) state_next = PENDING;
      PENDING: if (green)    state_next = SERVING;
      SERVING: if (!green)   state_next = det ? PENDING : IDLE;
      default:               state_next = IDLE;
    endcase
  end

  // Stuck-detector timer: continuous debounced-high cycles, saturating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                scnt <= '0;
    else if (!det)                            scnt <= '0;
    else if (scnt != SCNT_W'(STUCK_CYCLES))   scnt <= scnt + 1'b1;
  end

  // Fault rises on the same edge the timer reaches its limit.
  assign fault_set = det && (scnt == SCNT_W'(STUCK_CYCLES - 1));

  // Sticky fault flag; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) fault_q <= 1'b0;
    else       fault_q <= fault_q | fault_set;
  end

  // Registered request: pending state, or a permanent recall once faulted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sensor_q <= 1'b0;
    else       sensor_q <= (state_next == PENDING) | fault_q | fault_set;
  end

  // Saturating arrival counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           count_q <= '0;
    else if (det_rise && (count_q != '1)) count_q <= count_q + 1'b1;
  end

  assign bus.sensor        = sensor_q;
  assign bus.fault         = fault_q;
  assign bus.vehicle_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_vehicle_sensor_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vehicle_sensor_conditioner                                        |
// | Self-checking bench: directed vector table, corner-case sequences    |
// | and randomized stimulus against a behavioural reference model.       |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_vehicle_sensor_conditioner;

  localparam int DEBOUNCE     = 4;
  localparam int STUCK_CYCLES = 16;
  localparam int CNT_W        = 8;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  logic clk;
  logic reset;

  vehicle_sensor_conditioner_if #(.CNT_W(CNT_W)) bus ();

  vehicle_sensor_conditioner #(
    .DEBOUNCE     (DEBOUNCE),
    .STUCK_CYCLES (STUCK_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: raw history through two sync stages, a run-length
  // debounce, a "waiting"/"being served" request and plain counters.
  bit m_s1, m_s2, m_det, m_detq;
  int m_run, m_scnt, m_count;
  bit m_waiting, m_served, m_fault, m_sensor;

  function automatic void model_clear();
    m_s1 = 0; m_s2 = 0; m_det = 0; m_detq = 0;
    m_run = 0; m_scnt = 0; m_count = 0;
    m_waiting = 0; m_served = 0; m_fault = 0; m_sensor = 0;
  endfunction

  function automatic void model_step(input bit loop, input bit [1:0] side);
    bit arrival;
    bit green;
    bit det_before;
    if (reset) begin
      model_clear();
      return;
    end
    arrival    = m_det && !m_detq;
    green      = (side == 2'b10);
    det_before = m_det;
    if (m_waiting) begin
      if (green) begin m_waiting = 0; m_served = 1; end
    end else if (m_served) begin
      if (!green) begin m_served = 0; m_waiting = m_det; end
    end else if (arrival) begin
      m_waiting = 1;
    end
    if (arrival && m_count < CNT_MAX) m_count++;
    if (m_det) begin
      if (m_scnt < STUCK_CYCLES) m_scnt++;
      if (m_scnt == STUCK_CYCLES) m_fault = 1;
    end else begin
      m_scnt = 0;
    end
    if (m_s2 != m_det) begin
      m_run++;
      if (m_run == DEBOUNCE) begin m_det = m_s2; m_run = 0; end
    end else begin
      m_run = 0;
    end
    m_detq   = det_before;
    m_s2     = m_s1;
    m_s1     = loop;
    m_sensor = m_waiting | m_fault;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("model_sensor", 32'(bus.sensor), 32'(m_sensor));
    check("model_fault",  32'(bus.fault),  32'(m_fault));
    check("model_count",  32'(bus.vehicle_count), 32'(m_count));
  endtask

  // One clock: drive inputs, advance model with the edge, sample 1 ns later.
  task automatic step(input bit loop, input bit [1:0] side);
    bus.loop_raw   = loop;
    bus.side_light = side;
    @(posedge clk);
    model_step(loop, side);
    #1;
    compare_model();
  endtask

  // One vehicle: 8 cycles on the loop, 8 cycles clear.
  task automatic arrive(input bit [1:0] side, output int sensor_hi);
    sensor_hi = 0;
    for (int i = 0; i < 16; i++) begin
      step(i < 8, side);
      if (bus.sensor === 1'b1) sensor_hi++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(0, 2'b00);
    step(0, 2'b00);
    reset = 1'b0;
  endtask

  typedef struct {
    bit       loop;
    bit [1:0] side;
    bit       sensor;
    int       count;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit l, input bit [1:0] s, input bit sn, input int c, input int n);
    vec_t v;
    v.loop = l; v.side = s; v.sensor = sn; v.count = c;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int hi;
    int acc;
    int fault_edge;
    int run_left;
    int side_left;
    bit lvl;
    bit [1:0] side_r;

    model_clear();
    reset          = 1'b1;
    bus.loop_raw   = 1'b0;
    bus.side_light = 2'b00;
    #3;
    check("reset_sensor", 32'(bus.sensor), 0);
    check("reset_fault",  32'(bus.fault), 0);
    check("reset_count",  32'(bus.vehicle_count), 0);
    step(0, 2'b00);
    step(0, 2'b00);
    reset = 1'b0;
    step(0, 2'b00);

    // Glitch, latency, serve and re-request vectors.
    add(1, 2'b00, 0, 0, 3);   // 3-cycle glitch
    add(0, 2'b00, 0, 0, 7);
    add(1, 2'b00, 0, 0, 6);   // held: edges 0..5
    add(1, 2'b00, 1, 1, 2);   // request after edge 6
    add(1, 2'b10, 0, 1, 2);   // green serves
    add(1, 2'b00, 1, 1, 1);   // still on loop -> request again
    add(1, 2'b10, 0, 1, 1);
    add(0, 2'b10, 0, 1, 7);   // leaves during green
    add(0, 2'b00, 0, 1, 2);   // back to idle
    foreach (tbl[i]) begin
      step(tbl[i].loop, tbl[i].side);
      check("tbl_sensor", 32'(bus.sensor), 32'(tbl[i].sensor));
      check("tbl_count",  32'(bus.vehicle_count), 32'(tbl[i].count));
    end

    // Arrivals during green: only the first (arriving while idle) flashes
    // the request for one cycle; after green a new arrival requests.
    do_reset();
    step(0, 2'b10);
    acc = 0;
    arrive(2'b10, hi); acc += hi;
    arrive(2'b10, hi); acc += hi;
    check("green_sensor_cycles", 32'(acc), 1);
    step(0, 2'b00);
    step(0, 2'b00);
    check("idle_after_green", 32'(bus.sensor), 0);
    arrive(2'b00, hi);
    check("post_green_request", 32'(bus.sensor), 1);
    check("three_arrivals", 32'(bus.vehicle_count), 3);

    // Saturation at all-ones.
    for (int i = 0; i < 300 && bus.vehicle_count != CNT_MAX; i++) arrive(2'b00, hi);
    check("count_reach_max", 32'(bus.vehicle_count), CNT_MAX);
    arrive(2'b00, hi);
    check("count_saturates", 32'(bus.vehicle_count), CNT_MAX);

    // Stuck detector through a full serve cycle.
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 2'b00);
    fault_edge = -1;
    for (int e = 0; e < 40; e++) begin
      step(1, ((e / 6) % 2) ? 2'b10 : 2'b00);
      if (fault_edge < 0 && bus.fault === 1'b1) fault_edge = e;
    end
    check("fault_edge", 32'(fault_edge), DEBOUNCE + 1 + STUCK_CYCLES);
    step(1, 2'b10);
    step(1, 2'b10);
    check("fault_recall_green", 32'(bus.sensor), 1);
    for (int i = 0; i < 15; i++) step(0, 2'b00);
    check("fault_sticky", 32'(bus.fault), 1);
    check("fault_sensor_low_loop", 32'(bus.sensor), 1);

    // Asynchronous reset in the middle of a pending request with fault set.
    for (int i = 0; i < 8; i++) step(1, 2'b00);
    #3;
    reset = 1'b1;
    #1;
    check("async_rst_sensor", 32'(bus.sensor), 0);
    check("async_rst_fault",  32'(bus.fault), 0);
    check("async_rst_count",  32'(bus.vehicle_count), 0);
    model_clear();
    step(0, 2'b00);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) step(0, 2'b00);
    check("post_reset_idle", 32'(bus.sensor), 0);

    // Randomized traffic, lamp sequencing and occasional resets.
    lvl = 0; run_left = 0; side_left = 0; side_r = 2'b00;
    for (int c = 0; c < 3000; c++) begin
      if (run_left == 0) begin
        lvl      = $urandom_range(0, 1);
        run_left = $urandom_range(1, 14);
      end
      if (side_left == 0) begin
        side_r    = 2'($urandom_range(0, 3));
        side_left = $urandom_range(1, 20);
      end
      reset = ($urandom_range(0, 499) == 0);
      step(lvl, side_r);
      run_left--;
      side_left--;
    end
    reset = 1'b0;
    step(0, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
